// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin arbiter that connects several cache-bus masters
// to one downstream cache-bus port. A grant is held for a whole burst, until
// the downstream beat carrying last is accepted, so refills and write-backs
// never interleave.
//
//   state | meaning
//   IDLE  | busy=0: outputs zero, pick a winner starting at prio
//   BUSY  | busy=1: ireqs[sel] <-> downstream pass-through until ready&&last

package cbus_pkg;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_t   len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0] iresps,
  output cbus_req_t                   oreq,
  input  cbus_resp_t                  oresp
);

  localparam int          SEL_W = $clog2(NUM_INPUTS);
  localparam int unsigned N_U   = NUM_INPUTS;

  typedef logic [SEL_W-1:0] idx_t;

  logic busy;
  logic busy_next;
  idx_t sel;
  idx_t sel_next;
  idx_t prio;
  idx_t prio_next;
  logic found;
  idx_t winner;

  // (base + ofs) mod NUM_INPUTS; both operands are already below NUM_INPUTS,
  // so a single conditional subtract covers non-power-of-two counts.
  function automatic idx_t wrap_add(input idx_t base, input int unsigned ofs);
    int unsigned sum;
    sum = 32'(base) + ofs;
    if (sum >= N_U) sum = sum - N_U;
    return SEL_W'(sum);
  endfunction

  // Round-robin scan: first valid requester starting at prio.
  always_comb begin
    found  = 1'b0;
    winner = prio;
    for (int unsigned k = 0; k < N_U; k++) begin
      if (!found && ireqs[wrap_add(prio, k)].valid) begin
        found  = 1'b1;
        winner = wrap_add(prio, k);
      end
    end
  end

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= 1'b0;
      sel  <= '0;
      prio <= '0;
    end else begin
      busy <= busy_next;
      sel  <= sel_next;
      prio <= prio_next;
    end
  end

  // Next state: grant in IDLE, release on the accepted last beat.
  always_comb begin
    busy_next = busy;
    sel_next  = sel;
    prio_next = prio;
    if (!busy) begin
      if (found) begin
        busy_next = 1'b1;
        sel_next  = winner;
      end
    end else if (oresp.ready && oresp.last) begin
      busy_next = 1'b0;
      prio_next = wrap_add(sel, 1);
    end
  end

  // Outputs: zero in IDLE (stray oresp ignored), pure pass-through in BUSY.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (busy) begin
      oreq        = ireqs[sel];
      iresps[sel] = oresp;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: read/write bursts, arbitration order,
// asynchronous reset mid-burst and stray downstream responses while idle.
// Read data and grant order are predicted into queues when stimulus is
// applied and consumed when the arbiter delivers them.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 2;

  logic                 clk;
  logic                 resetn;
  cbus_req_t  [N-1:0]   ireqs;
  cbus_resp_t [N-1:0]   iresps;
  cbus_req_t            oreq;
  cbus_resp_t           oresp;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] wr_q[$];
  int          grant_q[$];

  cbus_arbiter #(.NUM_INPUTS(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] addr_of(input int m);
    return (m == 0) ? 32'h8000_0010 : 32'h9000_0200;
  endfunction

  // Memory model: beat data derived from the address it actually sees.
  function automatic logic [31:0] mem_word(input logic [31:0] addr, input int b);
    return addr + 32'h0101_0000 * 32'(b + 1);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req_read(input int m, input cbus_len_t len);
    ireqs[m].valid    = 1'b1;
    ireqs[m].is_write = 1'b0;
    ireqs[m].size     = 3'd2;
    ireqs[m].addr     = addr_of(m);
    ireqs[m].strobe   = 4'h0;
    ireqs[m].data     = 32'h0;
    ireqs[m].len      = len;
    ireqs[m].burst    = 2'b01;
  endtask

  task automatic expect_read(input int m, input int nbeats);
    for (int b = 0; b < nbeats; b++) exp_q.push_back(mem_word(addr_of(m), b));
  endtask

  // Called at a negedge (or just after); returns just after the grant is seen.
  task automatic wait_grant(input string tag, output int m);
    bit seen;
    seen = 1'b0;
    m = (grant_q.size() != 0) ? grant_q.pop_front() : 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      #1;
      if (oreq.valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_seen"}, 128'(seen), 128'(1));
    chk(tag, 128'(oreq.addr), 128'(addr_of(m)));
  endtask

  // Drive `count` read beats of a `total`-beat burst for granted master m.
  task automatic serve(input int m, input int total, input int count);
    logic [31:0] exp_d;
    for (int b = 0; b < count; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = (b == total - 1);
      oresp.data  = mem_word(oreq.addr, b);
      #1;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 128'(1), 128'(0));
        exp_d = 32'h0;
      end else begin
        exp_d = exp_q.pop_front();
      end
      chk("rd_ready", 128'(iresps[m].ready), 128'(1));
      chk("rd_data", 128'(iresps[m].data), 128'(exp_d));
      chk("rd_last", 128'(iresps[m].last), 128'(b == total - 1));
      for (int o = 0; o < N; o++)
        if (o != m) chk("other_resp", 128'(iresps[o]), 128'(0));
      @(negedge clk);
    end
    oresp = '0;
  endtask

  initial begin
    int m;
    resetn = 1'b0;
    ireqs  = '0;
    oresp  = '0;
    #1;
    chk("rst_oreq", 128'(oreq), 128'(0));
    chk("rst_iresps", 128'(iresps), 128'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Single read burst, master 0.
    req_read(0, MLEN4);
    expect_read(0, 4);
    #1;
    chk("t1_idle_before", 128'(oreq.valid), 128'(0));
    @(negedge clk);
    #1;
    chk("t1_grant_latency", 128'(oreq.valid), 128'(1));
    chk("t1_addr", 128'(oreq.addr), 128'(32'h8000_0010));
    chk("t1_len", 128'(oreq.len), 128'(MLEN4));
    serve(0, 4, 4);
    ireqs[0].valid = 1'b0;
    #1;
    chk("t1_idle_after", 128'(oreq.valid), 128'(0));
    chk("t1_iresps_zero", 128'(iresps), 128'(0));
    chk("t1_sb_empty", 128'(exp_q.size()), 128'(0));

    // Simultaneous requests right after reset.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    req_read(0, MLEN4);
    req_read(1, MLEN4);
    expect_read(0, 4);
    expect_read(1, 4);
    @(negedge clk);
    #1;
    chk("t2_first_grant", 128'(oreq.addr), 128'(32'h8000_0010));
    chk("t2_m1_waiting", 128'(iresps[1].ready), 128'(0));
    serve(0, 4, 4);
    ireqs[0].valid = 1'b0;
    #1;
    chk("t2_bubble", 128'(oreq.valid), 128'(0));
    chk("t2_bubble_m1", 128'(iresps[1].ready), 128'(0));
    @(negedge clk);
    #1;
    chk("t2_second_grant_valid", 128'(oreq.valid), 128'(1));
    chk("t2_second_grant_addr", 128'(oreq.addr), 128'(32'h9000_0200));
    serve(1, 4, 4);
    ireqs[1].valid = 1'b0;

    // Round-robin with both masters requesting continuously.
    req_read(0, MLEN2);
    req_read(1, MLEN2);
    grant_q = '{0, 1, 0, 1};
    for (int t = 0; t < 4; t++) expect_read(grant_q[t], 2);
    for (int t = 0; t < 4; t++) begin
      wait_grant("t3_rr_grant", m);
      serve(m, 2, 2);
    end
    ireqs = '0;

    // Write burst: data and strobe follow the master beat by beat.
    ireqs[1].valid    = 1'b1;
    ireqs[1].is_write = 1'b1;
    ireqs[1].size     = 3'd2;
    ireqs[1].addr     = 32'h9000_0200;
    ireqs[1].strobe   = 4'hf;
    ireqs[1].data     = 32'h1111_1111;
    ireqs[1].len      = MLEN4;
    ireqs[1].burst    = 2'b01;
    wr_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    @(negedge clk);
    #1;
    chk("t4_write_grant", 128'(oreq.is_write), 128'(1));
    for (int b = 0; b < 4; b++) begin
      ireqs[1].data = 32'h1111_1111 * 32'(b + 1);
      oresp.ready   = 1'b1;
      oresp.last    = (b == 3);
      oresp.data    = 32'h0;
      #1;
      chk("t4_wr_data", 128'(oreq.data), 128'(wr_q.pop_front()));
      chk("t4_wr_strobe", 128'(oreq.strobe), 128'(4'hf));
      chk("t4_wr_ready", 128'(iresps[1].ready), 128'(1));
      @(negedge clk);
    end
    oresp = '0;
    ireqs = '0;

    // Move prio away from 0, then reset in the middle of a burst.
    req_read(0, MLEN1);
    expect_read(0, 1);
    grant_q.push_back(0);
    wait_grant("t5_pre_grant", m);
    serve(m, 1, 1);
    ireqs[0].valid = 1'b0;
    req_read(1, MLEN4);
    expect_read(1, 4);
    grant_q.push_back(1);
    wait_grant("t5_burst_grant", m);
    serve(m, 4, 2);
    oresp.ready = 1'b1;
    oresp.last  = 1'b0;
    oresp.data  = 32'hdead_beef;
    resetn      = 1'b0;
    #1;
    chk("t5_rst_oreq_valid", 128'(oreq.valid), 128'(0));
    chk("t5_rst_oreq", 128'(oreq), 128'(0));
    chk("t5_rst_iresps", 128'(iresps), 128'(0));
    exp_q.delete();
    oresp = '0;
    req_read(0, MLEN1);
    req_read(1, MLEN1);
    expect_read(0, 1);
    expect_read(1, 1);
    grant_q.push_back(0);
    grant_q.push_back(1);
    @(negedge clk);
    resetn = 1'b1;
    wait_grant("t5_post_rst_grant", m);
    serve(m, 1, 1);
    ireqs[0].valid = 1'b0;
    wait_grant("t5_m1_grant", m);
    serve(m, 1, 1);
    ireqs[1].valid = 1'b0;

    // Stray ready/last while idle must be ignored.
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 32'hcafe_f00d;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t6_stray_iresps", 128'(iresps), 128'(0));
      chk("t6_stray_oreq", 128'(oreq.valid), 128'(0));
      @(negedge clk);
    end
    oresp = '0;
    req_read(0, MLEN1);
    req_read(1, MLEN1);
    expect_read(0, 1);
    grant_q.push_back(0);
    wait_grant("t6_after_stray_grant", m);
    serve(m, 1, 1);
    ireqs = '0;
    #1;
    chk("final_sb_empty", 128'(exp_q.size()), 128'(0));
    chk("final_idle", 128'(oreq.valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Arbitrates between several cache-side cache-bus masters (DCache, ICache, uncached path) and one downstream cache-bus port toward the AXI bridge. It sits directly downstream of the data cache's `creq`/`cresp` port. It grants one requester at a time, round-robin, and holds the grant for a whole burst. Grant locks from request selection until the beat carrying `last`, so 4-word line refills and write-backs are never interleaved.

## Interface
- `NUM_INPUTS`, default 2: number of requesting masters; must be ≥ 2. Index 0 is the DCache port.
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `resetn`, input, 1: reset, asynchronous and active-low.
- `ireqs`, input, `cbus_req_t [NUM_INPUTS-1:0]`: requests from the masters. Fields used: `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`, `burst`.
- `iresps`, output, `cbus_resp_t [NUM_INPUTS-1:0]`: per-master responses. Fields: `ready`, `last`, `data`.
- `oreq`, output, `cbus_req_t`: request to the downstream bus.
- `oresp`, input, `cbus_resp_t`: response from the downstream bus.

## Operation
- State register `busy` (IDLE/BUSY), grant index `sel` of width `$clog2(NUM_INPUTS)`, and round-robin pointer `prio` (same width).
- **IDLE**
  - `oreq` is all-zero.
  - All `iresps` are all-zero.
  - Winner: the first `i` with `ireqs[i].valid`, scanning `prio`, `prio+1`, … modulo `NUM_INPUTS`.
  - If a winner exists: `sel <= i`, `busy <= 1` on the next edge.
  - If no input is valid, stay IDLE.
- **BUSY**
  - `oreq = ireqs[sel]`, passed through combinationally so write data and strobe track the master beat by beat.
  - `iresps[sel] = oresp`. All other `iresps` are zero.
  - Non-selected masters see `ready=0` and keep waiting; their requests must stay stable.
- **Exit from BUSY**
  - Condition: `oresp.ready && oresp.last` in a cycle.
  - Next edge: `busy <= 0` and `prio <= (sel+1) mod NUM_INPUTS`.
  - Wrap-around: `sel = NUM_INPUTS-1` gives `prio = 0`.
- If the granted master drops `valid` while BUSY, `oreq.valid` drops with it. The grant is kept until `ready && last` is seen; no timeout.
- Simultaneous requests are resolved by `prio` alone. After every completed transaction, the finished master has lowest priority.
- `oresp` is ignored in IDLE, including any stray `ready`.
- Reset at any time, including mid-burst:
  - `busy = 0`, `sel = 0`, `prio = 0` immediately.
  - `oreq` and all `iresps` read zero while `resetn` is low.
  - The interrupted burst is abandoned; downstream cleanup is the AXI bridge's concern.

## Timing
- Grant latency: one cycle. A request valid at edge N drives `oreq.valid=1` from the cycle after edge N, provided the arbiter was IDLE at edge N.
- Turnaround: one IDLE bubble cycle after each `last` beat, then a new grant. Minimum back-to-back spacing is last beat → 1 idle cycle → next `oreq.valid`.
- BUSY pass-through paths, both purely combinational with zero added latency:
  - `ireqs[sel]` → `oreq`
  - `oresp` → `iresps[sel]`
- Reset values of all outputs: `oreq = '0`, `iresps = '0`.

## Test plan
- **Single read burst.** Master 0 requests `addr=32'h8000_0010`, `len=MLEN4`, `is_write=0`. Memory returns 4 beats, `last` on the 4th.
  - Required: `oreq.valid` rises one cycle after the request.
  - Master 0 receives `data` beats `D0..D3` with `last` on `D3`.
  - Arbiter is IDLE one cycle after `last`.
- **Simultaneous requests after reset.** Both masters assert `valid` in the same cycle.
  - Required: master 0 granted first. Master 1 sees `ready=0` throughout.
  - Master 1 granted in the second cycle after master 0's `last`.
- **Round-robin fairness.** Both masters hold requests continuously for 4 transactions.
  - Required: grant order 0, 1, 0, 1.
- **Write burst pass-through.** Master 1 write, `len=MLEN4`; it changes `data`/`strobe` each beat (`32'h1111_1111` … `32'h4444_4444`, `strobe=4'hf`).
  - Required: `oreq.data` equals the master's data in the same cycle on every beat.
- **Reset mid-burst.** Assert `resetn=0` after beat 2 of a 4-beat read.
  - Required: `oreq.valid=0` and `iresps` zero immediately (asynchronous).
  - After release, a new request from master 1 is granted with `prio=0` scanning.
- **Stray ready in IDLE.** Drive `oresp.ready=1`, `last=1` with no requests pending.
  - Required: no state change; all `iresps` stay zero.
